if_fetch_unit: RTL



---
 rtl/if_fetch_unit.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: sequential PC, credit-limited imem requests, in-order response FIFO to decode.
// Optional hlt-opcode fetch stop is built when IF_HALT_DETECT_EN is defined.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IsBranchTaken,
  input  logic [31:0] BranchPC,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } fetchState_e;

  fetchState_e   state_r, stateNext_s;
  logic [31:0]   pc_r;
  logic [31:0]   instMem_r   [FIFO_DEPTH];
  logic [31:0]   instPcMem_r [FIFO_DEPTH];
  logic [31:0]   reqPcMem_r  [FIFO_DEPTH];
  logic [PW-1:0] instRd_r, instWr_r, reqRd_r, reqWr_r;
  logic [CW-1:0] instCount_r, outstanding_r, discard_r;
  logic [CW-1:0] instCountNext_s, outstandingNext_s, discardNext_s;
  logic          halted_s, credit_s, creditNext_s, busy_s;
  logic          reqFire_s, push_s, pop_s, hltSeen_s;
  logic          unusedBranchLsb_s;

  assign unusedBranchLsb_s = ^BranchPC[1:0];

  assign halted_s       = (state_r == HALT);
  assign credit_s       = ({1'b0, instCount_r} + {1'b0, outstanding_r}) < (CW+1)'(FIFO_DEPTH);
  assign imem_req_valid = !reset && !IsBranchTaken && credit_s && !halted_s;
  assign imem_req_addr  = pc_r;
  assign reqFire_s      = imem_req_valid && imem_req_ready;
  assign push_s         = imem_rsp_valid && (discard_r == '0) && !IsBranchTaken;
  assign pop_s          = inst_valid && inst_ready && !IsBranchTaken;

  assign inst_valid = (instCount_r != '0);
  assign inst       = instMem_r[instRd_r];
  assign inst_pc    = instPcMem_r[instRd_r];

`ifdef IF_HALT_DETECT_EN
  assign hltSeen_s = push_s && (imem_rsp_data[31:27] == 5'b11111);
`else
  assign hltSeen_s = 1'b0;
`endif

  // Occupancy, outstanding and discard bookkeeping for the coming edge
  always_comb begin
    outstandingNext_s = outstanding_r;
    instCountNext_s   = instCount_r;
    discardNext_s     = discard_r;
    if (reqFire_s && !imem_rsp_valid) begin
      outstandingNext_s = outstanding_r + CW'(1);
    end else if (imem_rsp_valid && !reqFire_s) begin
      outstandingNext_s = outstanding_r - CW'(1);
    end else begin
      outstandingNext_s = outstanding_r;
    end
    if (IsBranchTaken) begin
      instCountNext_s = '0;
    end else if (push_s && !pop_s) begin
      instCountNext_s = instCount_r + CW'(1);
    end else if (pop_s && !push_s) begin
      instCountNext_s = instCount_r - CW'(1);
    end else begin
      instCountNext_s = instCount_r;
    end
    // Everything still in flight after a redirect belongs to the old path
    if (IsBranchTaken) begin
      discardNext_s = outstandingNext_s;
    end else if (imem_rsp_valid && (discard_r != '0)) begin
      discardNext_s = discard_r - CW'(1);
    end else begin
      discardNext_s = discard_r;
    end
  end

  assign creditNext_s = ({1'b0, instCountNext_s} + {1'b0, outstandingNext_s}) < (CW+1)'(FIFO_DEPTH);
  assign busy_s       = !creditNext_s || (imem_req_valid && !imem_req_ready);

  // Fetch FSM next-state; a redirect always returns to FETCH
  always_comb begin
    stateNext_s = state_r;
    if (IsBranchTaken) begin
      stateNext_s = FETCH;
    end else begin
      case (state_r)
        FETCH:   stateNext_s = hltSeen_s ? HALT : (busy_s ? STALL : FETCH);
        STALL:   stateNext_s = hltSeen_s ? HALT : (creditNext_s ? FETCH : STALL);
        HALT:    stateNext_s = HALT;
        default: stateNext_s = FETCH;
      endcase
    end
  end

  // PC, counters and FSM state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= FETCH;
      pc_r          <= RESET_PC;
      instCount_r   <= '0;
      outstanding_r <= '0;
      discard_r     <= '0;
    end else begin
      state_r       <= stateNext_s;
      instCount_r   <= instCountNext_s;
      outstanding_r <= outstandingNext_s;
      discard_r     <= discardNext_s;
      if (IsBranchTaken) begin
        pc_r <= {BranchPC[31:2], 2'b00};
      end else if (reqFire_s) begin
        pc_r <= pc_r + 32'd4;
      end else begin
        pc_r <= pc_r;
      end
    end
  end

  // Issued-address FIFO shadowing the request stream; drained by every response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reqRd_r <= '0;
      reqWr_r <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) reqPcMem_r[i] <= 32'd0;
    end else begin
      if (reqFire_s) begin
        reqPcMem_r[reqWr_r] <= pc_r;
        reqWr_r             <= reqWr_r + PW'(1);
      end
      if (imem_rsp_valid) begin
        reqRd_r <= reqRd_r + PW'(1);
      end
    end
  end

  // Instruction FIFO toward decode; a redirect empties it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instRd_r <= '0;
      instWr_r <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instMem_r[i]   <= 32'd0;
        instPcMem_r[i] <= 32'd0;
      end
    end else if (IsBranchTaken) begin
      instRd_r <= '0;
      instWr_r <= '0;
    end else begin
      if (push_s) begin
        instMem_r[instWr_r]   <= imem_rsp_data;
        instPcMem_r[instWr_r] <= reqPcMem_r[reqRd_r];
        instWr_r              <= instWr_r + PW'(1);
      end
      if (pop_s) begin
        instRd_r <= instRd_r + PW'(1);
      end
    end
  end

  // A response can only answer a request that was actually issued
  assert property (@(posedge clk) disable iff (reset) imem_rsp_valid |-> (outstanding_r != '0));

endmodule
